uart_rx: RTL and testbench

Serial receiver that takes the UART line driven by the team's transmitter and returns parallel bytes to fabric logic. It synchronises the asynchronous line, finds the start bit, samples each bit at mid-bit using a clock-cycle counter, and checks the stop bit. It holds each received byte in a one-entry output register with a valid/ready handshake. It is the consumer stage on the opposite end of the link from `uart_tx`: same frame format, same bit order, same baud tick arithmetic.

---
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : UART receiver with 2-FF line synchroniser, mid-bit sampling,
//            stop-bit check and a one-entry valid/ready output register.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic       fpga_clk,
    input  logic       nrst,
    input  logic       sin,
    output logic [7:0] dout,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy_rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          sync1, sin_s;
    logic          byte_done, stop_bad;

    always_ff @(posedge fpga_clk) begin
        if (!nrst) begin
            sync1   <= 1'b1;
            sin_s   <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            sync1   <= sin;
            sin_s   <= sync1;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (!sin_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                cnt_n = cnt + 1'b1;
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    // A line that is high again at mid start bit was only a glitch.
                    if (!sin_s) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                cnt_n = cnt + 1'b1;
                if (cnt == FULL_M1) begin
                    cnt_n     = '0;
                    bit_idx_n = bit_idx + 1'b1;
                    if (MSB_FIRST)
                        shreg_n = {shreg[6:0], sin_s};
                    else
                        shreg_n = {sin_s, shreg[7:1]};
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                end
            end
            STOP: begin
                cnt_n = cnt + 1'b1;
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (sin_s)
                        byte_done = 1'b1;
                    else
                        stop_bad = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk) begin
        if (!nrst) begin
            dout      <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (byte_done) begin
                // A same-cycle accept frees the register for the new byte.
                if (!rx_valid || rx_ready) begin
                    dout     <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy_rx = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx: directed and random frames
//            compared against frame-level expectations.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int C   = 16;
    localparam int H   = C / 2;
    localparam int LAT = 2 + H + 9 * C;

    logic       fpga_clk = 1'b0;
    logic       nrst     = 1'b0;
    logic       sin      = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] dout;
    logic       rx_valid, frame_err, overrun, busy_rx;

    uart_rx #(.CLKS_PER_BIT(C), .MSB_FIRST(1'b1)) dut (
        .fpga_clk (fpga_clk),
        .nrst     (nrst),
        .sin      (sin),
        .dout     (dout),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy_rx  (busy_rx)
    );

    always #5 fpga_clk = ~fpga_clk;

    int cyc = 0;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Event log: rising edges of rx_valid, and each cycle frame_err/overrun is high.
    int         rx_cyc[$];
    logic [7:0] rx_dat[$];
    int         fe_cyc[$];
    int         ov_cyc[$];
    int         busy_cnt = 0;
    logic       pv = 1'b0;

    always @(negedge fpga_clk) begin
        if (rx_valid && !pv) begin
            rx_cyc.push_back(cyc);
            rx_dat.push_back(dout);
        end
        if (frame_err) fe_cyc.push_back(cyc);
        if (overrun)   ov_cyc.push_back(cyc);
        if (busy_rx)   busy_cnt <= busy_cnt + 1;
        pv <= rx_valid;
    end

    logic [7:0] sv[4] = '{8'h00, 8'hFF, 8'h80, 8'h01};
    int         ks[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_bit(input logic b);
        sin = b;
        repeat (C) tick();
    endtask

    // Starts at #1 after an edge; k is the edge that first captures the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, output int k);
        k = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[7-i]);
        drive_bit(stop);
    endtask

    task automatic expect_rx(input string tag, input int exp_cyc, input logic [7:0] exp_d);
        int c;
        logic [7:0] dd;
        if (rx_cyc.size() == 0) begin
            chk({tag, "_missing"}, 0, 1);
        end else begin
            c  = rx_cyc.pop_front();
            dd = rx_dat.pop_front();
            chk({tag, "_cyc"}, c, exp_cyc);
            chk({tag, "_data"}, dd, exp_d);
        end
    endtask

    task automatic expect_fe(input string tag, input int exp_cyc);
        if (fe_cyc.size() == 0) chk({tag, "_missing"}, 0, 1);
        else                    chk({tag, "_cyc"}, fe_cyc.pop_front(), exp_cyc);
    endtask

    task automatic expect_ov(input string tag, input int exp_cyc);
        if (ov_cyc.size() == 0) chk({tag, "_missing"}, 0, 1);
        else                    chk({tag, "_cyc"}, ov_cyc.pop_front(), exp_cyc);
    endtask

    task automatic expect_quiet(input string tag);
        chk({tag, "_no_rx"}, rx_cyc.size(), 0);
        chk({tag, "_no_fe"}, fe_cyc.size(), 0);
        chk({tag, "_no_ov"}, ov_cyc.size(), 0);
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        int k, k2, k3, b0;
        logic [7:0] d;
        logic st;

        repeat (4) @(posedge fpga_clk);
        #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_valid", rx_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy_rx, 0);
        nrst = 1'b1;
        tick();

        // Basic byte held until accepted
        send_frame(8'hA5, 1'b1, k);
        sin = 1'b1;
        expect_rx("basic", k + LAT, 8'hA5);
        idle(20);
        chk("basic_hold_valid", rx_valid, 1);
        chk("basic_hold_dout", dout, 8'hA5);
        consume();
        chk("basic_release", rx_valid, 0);
        expect_quiet("basic");

        // Short low glitch
        b0  = busy_cnt;
        sin = 1'b0;
        repeat (5) tick();
        sin = 1'b1;
        idle(30);
        chk("glitch_busy_cycles", busy_cnt - b0, H);
        expect_quiet("glitch");

        // Framing error then a good frame
        send_frame(8'h3C, 1'b0, k);
        sin = 1'b1;
        idle(C);
        expect_fe("ferr", k + LAT);
        chk("ferr_no_valid", rx_valid, 0);
        expect_quiet("ferr");
        send_frame(8'h55, 1'b1, k);
        sin = 1'b1;
        expect_rx("after_ferr", k + LAT, 8'h55);
        consume();

        // Overrun with no consumer
        idle(4);
        send_frame(8'h11, 1'b1, k);
        send_frame(8'h22, 1'b1, k2);
        sin = 1'b1;
        expect_rx("ovr_first", k + LAT, 8'h11);
        expect_ov("ovr", k2 + LAT);
        chk("ovr_keep_dout", dout, 8'h11);
        chk("ovr_keep_valid", rx_valid, 1);
        expect_quiet("ovr");
        consume();

        // Accept on exactly the second frame's stop-sample cycle
        idle(4);
        send_frame(8'h11, 1'b1, k);
        k2 = cyc + 1;
        fork
            send_frame(8'h22, 1'b1, k3);
            begin
                repeat (LAT) tick();
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
            end
        join
        sin = 1'b1;
        expect_rx("rescue_first", k + LAT, 8'h11);
        chk("rescue_k", k3, k2);
        chk("rescue_dout", dout, 8'h22);
        chk("rescue_valid", rx_valid, 1);
        expect_quiet("rescue");
        consume();

        // Back-to-back streaming with consumer always ready
        idle(4);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_frame(sv[i], 1'b1, ks[i]);
        sin = 1'b1;
        idle(4);
        for (int i = 0; i < 4; i++) expect_rx("stream", ks[i] + LAT, sv[i]);
        chk("stream_idle_valid", rx_valid, 0);
        expect_quiet("stream");

        // Random bytes, occasional bad stop bit
        for (int i = 0; i < 8; i++) begin
            d  = 8'($urandom);
            st = ($urandom_range(3) != 0);
            send_frame(d, st, k);
            if (!st) begin
                sin = 1'b1;
                idle(C);
                expect_fe("rand_fe", k + LAT);
            end else begin
                expect_rx("rand", k + LAT, d);
            end
        end
        sin = 1'b1;
        idle(4);
        expect_quiet("rand");

        // Reset in the middle of a frame while a byte is held
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, k);
        sin = 1'b1;
        idle(4);
        expect_rx("pre_rst", k + LAT, 8'h5A);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        sin = 1'b0;
        idle(H);
        chk("rst_mid_busy_before", busy_rx, 1);
        nrst = 1'b0;
        tick();
        chk("rst_mid_dout", dout, 8'h00);
        chk("rst_mid_valid", rx_valid, 0);
        chk("rst_mid_busy", busy_rx, 0);
        chk("rst_mid_ferr", frame_err, 0);
        chk("rst_mid_ovr", overrun, 0);
        sin = 1'b1;
        idle(3);
        nrst = 1'b1;
        idle(20);
        send_frame(8'hC3, 1'b1, k);
        sin = 1'b1;
        idle(4);
        expect_rx("post_rst", k + LAT, 8'hC3);
        expect_quiet("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
